// File: rtl/stim_fetch.sv
// Stimulus fetcher: walks RUN / BITMASK / END records from memory, drives the DUT,
// queues expected results for the checker. Define STIM_VEC_COUNT_EN to add vec_count.
module stim_fetch #(
   parameter int ADDR_WIDTH          = 20,
   parameter int DATA_WIDTH          = 16,
   parameter int VEC_WIDTH           = 24,
   parameter int ORV_WIDTH           = 8,
   parameter int CHF_WIDTH           = VEC_WIDTH + ADDR_WIDTH + ORV_WIDTH,
   parameter int SCC_WIDTH           = 5,
   parameter int SCD_WIDTH           = 24,
   parameter int RESULT_VECTOR_WORDS = 2,
   parameter int SETTLE_WIDTH        = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   vec_base,
   input  logic [ADDR_WIDTH-1:0]   res_base,
   input  logic [SETTLE_WIDTH-1:0] settle_cycles,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic                    mem_read,
   input  logic [DATA_WIDTH-1:0]   mem_readdata,
   input  logic                    mem_waitrequest,
   output logic [VEC_WIDTH-1:0]    dut_inputs,
   output logic                    capture,
   output logic [CHF_WIDTH-1:0]    cfifo_data,
   output logic                    cfifo_wrreq,
   input  logic                    cfifo_wrfull,
   output logic [SCC_WIDTH-1:0]    sc_cmd,
   output logic [SCD_WIDTH-1:0]    sc_data,
   output logic                    sc_switching,
   input  logic                    sc_ready
`ifdef STIM_VEC_COUNT_EN
   ,output logic [15:0]            vec_count
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH_HDR, S_FETCH_RUN, S_APPLY, S_SETTLE, S_CAPTURE,
      S_PUSH, S_FETCH_MASK, S_WAIT_READY, S_MASK, S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] RVW = ADDR_WIDTH'(RESULT_VECTOR_WORDS);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   res_base_q, res_base_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [1:0]              wcnt_q, wcnt_d;
   logic [7:0]              hi_q, hi_d;
   logic [VEC_WIDTH-1:0]    in_q, in_d;
   logic [VEC_WIDTH-1:0]    exp_q, exp_d;
   logic [ORV_WIDTH-1:0]    orv_q, orv_d;
   logic [SCD_WIDTH-1:0]    mask_q, mask_d;
   logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
   logic [VEC_WIDTH-1:0]    dut_in_q, dut_in_d;
   logic [CHF_WIDTH-1:0]    cfd_q, cfd_d;
   logic                    err_q, err_d;
   logic                    fetch_st, accept;
   logic [ADDR_WIDTH-1:0]   res_addr;

   assign fetch_st    = (state_q == S_FETCH_HDR) || (state_q == S_FETCH_RUN) ||
                        (state_q == S_FETCH_MASK);
   assign accept      = fetch_st && !mem_waitrequest;
   assign mem_read    = fetch_st;
   assign mem_address = addr_q;
   assign busy        = (state_q != S_IDLE);
   assign error       = err_q;
   assign dut_inputs  = dut_in_q;
   assign cfifo_data  = cfd_q;
   assign res_addr    = res_base_q + idx_q * RVW;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         res_base_q <= '0;
         idx_q      <= '0;
         wcnt_q     <= '0;
         hi_q       <= '0;
         in_q       <= '0;
         exp_q      <= '0;
         orv_q      <= '0;
         mask_q     <= '0;
         settle_q   <= '0;
         dut_in_q   <= '0;
         cfd_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         res_base_q <= res_base_d;
         idx_q      <= idx_d;
         wcnt_q     <= wcnt_d;
         hi_q       <= hi_d;
         in_q       <= in_d;
         exp_q      <= exp_d;
         orv_q      <= orv_d;
         mask_q     <= mask_d;
         settle_q   <= settle_d;
         dut_in_q   <= dut_in_d;
         cfd_q      <= cfd_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      res_base_d   = res_base_q;
      idx_d        = idx_q;
      wcnt_d       = wcnt_q;
      hi_d         = hi_q;
      in_d         = in_q;
      exp_d        = exp_q;
      orv_d        = orv_q;
      mask_d       = mask_q;
      settle_d     = settle_q;
      dut_in_d     = dut_in_q;
      cfd_d        = cfd_q;
      err_d        = err_q;
      done         = 1'b0;
      capture      = 1'b0;
      cfifo_wrreq  = 1'b0;
      sc_cmd       = '0;
      sc_data      = '0;
      sc_switching = 1'b0;

      if (accept) addr_d = addr_q + ADDR_WIDTH'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = vec_base;
               res_base_d = res_base;
               idx_d      = '0;
               err_d      = 1'b0;
               state_d    = S_FETCH_HDR;
            end
         end
         S_FETCH_HDR: begin
            if (accept) begin
               hi_d   = mem_readdata[7:0];
               wcnt_d = '0;
               case (mem_readdata[15:8])
                  8'h80:   state_d = S_FETCH_RUN;
                  8'h01:   state_d = S_FETCH_MASK;
                  8'hFF:   state_d = S_DONE;
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_FETCH_RUN: begin
            if (accept) begin
               wcnt_d = wcnt_q + 2'd1;
               case (wcnt_q)
                  2'd0: in_d = {hi_q, mem_readdata};
                  2'd1: exp_d = {mem_readdata, exp_q[7:0]};
                  2'd2: begin
                     exp_d   = {exp_q[23:8], mem_readdata[15:8]};
                     orv_d   = mem_readdata[7:0];
                     state_d = S_APPLY;
                  end
                  default: ;
               endcase
            end
         end
         S_APPLY: begin
            // Checker entry is frozen here so it is stable from CAPTURE through PUSH.
            sc_switching = 1'b1;
            dut_in_d     = in_q;
            settle_d     = settle_cycles;
            cfd_d        = {exp_q, res_addr, orv_q};
            state_d      = S_SETTLE;
         end
         S_SETTLE: begin
            // A zero load behaves like one so SETTLE always lasts at least a cycle.
            if (settle_q <= SETTLE_WIDTH'(1)) state_d = S_CAPTURE;
            else settle_d = settle_q - SETTLE_WIDTH'(1);
         end
         S_CAPTURE: begin
            capture = 1'b1;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            if (!cfifo_wrfull) begin
               cfifo_wrreq = 1'b1;
               idx_d       = idx_q + ADDR_WIDTH'(1);
               state_d     = S_FETCH_HDR;
            end
         end
         S_FETCH_MASK: begin
            if (accept) begin
               mask_d  = {hi_q, mem_readdata};
               state_d = S_WAIT_READY;
            end
         end
         S_WAIT_READY: begin
            if (sc_ready) state_d = S_MASK;
         end
         S_MASK: begin
            sc_cmd  = SCC_WIDTH'(1);
            sc_data = mask_q;
            state_d = S_FETCH_HDR;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef STIM_VEC_COUNT_EN
   logic [15:0] vcnt_q;
   assign vec_count = vcnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) vcnt_q <= '0;
      else if (start && state_q == S_IDLE) vcnt_q <= '0;
      else if (cfifo_wrreq && vcnt_q != 16'hFFFF) vcnt_q <= vcnt_q + 16'd1;
   end
`endif

endmodule

// File: tb/tb_stim_fetch.sv
// Bench for stim_fetch: memory model plus a record-walking reference that predicts
// checker entries, masks and error state for directed and randomized programs.
`timescale 1ns/1ps
module tb_stim_fetch;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [19:0] vec_base = '0;
   logic [19:0] res_base = '0;
   logic [7:0]  settle_cycles = '0;
   logic        busy, done, error, mem_read, capture, cfifo_wrreq, sc_switching;
   logic [19:0] mem_address;
   logic [15:0] mem_readdata;
   logic        mem_waitrequest = 1'b0;
   logic [23:0] dut_inputs;
   logic [51:0] cfifo_data;
   logic        cfifo_wrfull = 1'b0;
   logic [4:0]  sc_cmd;
   logic [23:0] sc_data;
   logic        sc_ready = 1'b1;
`ifdef STIM_VEC_COUNT_EN
   logic [15:0] vec_count;
`endif

   stim_fetch dut (
`ifdef STIM_VEC_COUNT_EN
      .vec_count(vec_count),
`endif
      .clock(clock), .reset_n(reset_n), .start(start), .vec_base(vec_base),
      .res_base(res_base), .settle_cycles(settle_cycles), .busy(busy), .done(done),
      .error(error), .mem_address(mem_address), .mem_read(mem_read),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
      .dut_inputs(dut_inputs), .capture(capture), .cfifo_data(cfifo_data),
      .cfifo_wrreq(cfifo_wrreq), .cfifo_wrfull(cfifo_wrfull), .sc_cmd(sc_cmd),
      .sc_data(sc_data), .sc_switching(sc_switching), .sc_ready(sc_ready)
   );

   always #5 clock = ~clock;

   logic [15:0] mem [0:1023];
   always_comb mem_readdata = mem[mem_address[9:0]];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [51:0] obs_cf[$];
   logic [28:0] obs_sc[$];
   int          cap_cnt = 0, done_cnt = 0;
   int          last_apply = -1, last_cap = -1, first_gap = -1, ready_rise = -1;
   logic        pend = 1'b0, prev_stall = 1'b0, prev_ready = 1'b1;
   logic [19:0] prev_addr = '0;
   bit          ws_rand = 0, full_rand = 0;

   initial forever begin
      int st;
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
         pend = 1'b0;
         prev_stall = 1'b0;
         last_apply = -1;
      end else begin
         if (prev_stall) chk("stall_hold", {mem_read, mem_address}, {1'b1, prev_addr});
         prev_stall = mem_read && mem_waitrequest;
         prev_addr  = mem_address;
         if (sc_switching) last_apply = cyc;
         if (capture) begin
            st = (settle_cycles == 8'd0) ? 1 : int'(settle_cycles);
            cap_cnt++;
            chk("settle_gap", cyc - last_apply, 1 + st);
            last_cap = cyc;
            pend = 1'b1;
         end else if (pend) begin
            chk("no_fetch_in_push", mem_read, 0);
         end
         if (cfifo_wrreq) begin
            chk("wr_while_full", cfifo_wrfull, 0);
            if (obs_cf.size() == 0) first_gap = cyc - last_cap;
            obs_cf.push_back(cfifo_data);
            pend = 1'b0;
         end
         if (sc_ready && !prev_ready) ready_rise = cyc;
         prev_ready = sc_ready;
         if (sc_cmd != 5'd0) begin
            obs_sc.push_back({sc_cmd, sc_data});
            if (ready_rise >= 0) begin
               chk("mask_gap", cyc - ready_rise, 1);
               ready_rise = -1;
            end
         end
         if (done) done_cnt++;
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      mem_waitrequest = ws_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (full_rand) cfifo_wrfull = ($urandom_range(0, 3) == 0);
   end

   // ---------------- reference model ----------------
   logic [51:0] exp_cf[$];
   logic [28:0] exp_sc[$];
   logic        exp_err = 1'b0;
   int          exp_runs = 0;
   logic [23:0] exp_last_in = '0;
   logic [19:0] wp;

   function automatic logic [15:0] rd(input logic [19:0] a);
      return mem[a[9:0]];
   endfunction

   task automatic model(input logic [19:0] vb, input logic [19:0] rb);
      logic [19:0] a;
      logic [15:0] w0, w1, w2, w3;
      int          idx;
      bit          fin;
      a = vb; idx = 0; fin = 0;
      exp_cf.delete(); exp_sc.delete(); exp_err = 1'b0; exp_runs = 0;
      for (int g = 0; g < 64 && !fin; g++) begin
         w0 = rd(a);
         w1 = rd(a + 20'd1);
         case (w0[15:8])
            8'h80: begin
               w2 = rd(a + 20'd2);
               w3 = rd(a + 20'd3);
               exp_last_in = {w0[7:0], w1};
               exp_cf.push_back({w2, w3[15:8], rb + 20'(idx * 2), w3[7:0]});
               idx++; exp_runs++; a = a + 20'd4;
            end
            8'h01: begin
               exp_sc.push_back({5'b00001, w0[7:0], w1});
               a = a + 20'd2;
            end
            8'hFF: fin = 1;
            default: begin exp_err = 1'b1; fin = 1; end
         endcase
      end
   endtask

   task automatic put(input logic [15:0] w);
      mem[wp[9:0]] = w;
      wp = wp + 20'd1;
   endtask
   task automatic rec_run(input logic [23:0] vin, input logic [23:0] vexp, input logic [7:0] orv);
      put({8'h80, vin[23:16]}); put(vin[15:0]); put(vexp[23:8]); put({vexp[7:0], orv});
   endtask
   task automatic rec_mask(input logic [23:0] m);
      put({8'h01, m[23:16]}); put(m[15:0]);
   endtask

   task automatic do_start(input logic [19:0] vb, input logic [19:0] rb, input logic [7:0] st);
      vec_base = vb; res_base = rb; settle_cycles = st;
      model(vb, rb);
      obs_cf.delete(); obs_sc.delete();
      cap_cnt = 0; done_cnt = 0; first_gap = -1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("busy_run", busy, 1);
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 3000; n++) begin
         @(negedge clock);
         if (done) break;
      end
      if (n == 3000) chk("done_timeout", 1, 0);
      @(posedge clock); #1;
   endtask

   task automatic finish_check();
      chk("n_done", done_cnt, 1);
      chk("n_wr", obs_cf.size(), exp_cf.size());
      for (int i = 0; i < exp_cf.size() && i < obs_cf.size(); i++) chk("cf_entry", obs_cf[i], exp_cf[i]);
      chk("n_capture", cap_cnt, exp_runs);
      chk("n_sc", obs_sc.size(), exp_sc.size());
      for (int i = 0; i < exp_sc.size() && i < obs_sc.size(); i++) chk("sc_entry", obs_sc[i], exp_sc[i]);
      chk("error", error, exp_err);
      chk("dut_inputs", dut_inputs, exp_last_in);
      chk("busy_end", busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, {busy, done, error, mem_read, capture, cfifo_wrreq, sc_switching}, 0);
      chk({tag, "_addr"}, mem_address, 0);
      chk({tag, "_dut_in"}, dut_inputs, 0);
      chk({tag, "_cfifo"}, cfifo_data, 0);
      chk({tag, "_sc"}, {sc_cmd, sc_data}, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nrec, n;
      logic [19:0] vb, rb;
      for (int i = 0; i < 1024; i++) mem[i] = 16'hFF00;
      repeat (3) @(posedge clock);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // single RUN
      wp = 20'h100; rec_run(24'hABCDEF, 24'h123456, 8'h5A); put(16'hFF00);
      do_start(20'h100, 20'h08000, 8'd3);
      wait_done();
      finish_check();
      chk("t1_entry", obs_cf.size() > 0 ? obs_cf[0] : 52'h0, {24'h123456, 20'h08000, 8'h5A});
      chk("t1_dut_in", dut_inputs, 24'hABCDEF);

      // three RUNs, zero wait, then with random waitrequest
      wp = 20'h200;
      rec_run(24'h111111, 24'hA1A1A1, 8'h01);
      rec_run(24'h222222, 24'hB2B2B2, 8'h02);
      rec_run(24'h333333, 24'hC3C3C3, 8'h03);
      put(16'hFF00);
      do_start(20'h200, 20'h08000, 8'd0);
      wait_done();
      finish_check();
      for (int k = 0; k < 3 && k < obs_cf.size(); k++)
         chk("t2_res_addr", obs_cf[k][27:8], 20'h08000 + 20'(2 * k));
      ws_rand = 1;
      do_start(20'h200, 20'h08000, 8'd2);
      wait_done();
      ws_rand = 0;
      finish_check();

      // bitmask waits for sc_ready
      wp = 20'h300; rec_mask(24'h00FF0F); put(16'hFF00);
      sc_ready = 1'b0;
      do_start(20'h300, 20'h0, 8'd0);
      repeat (12) @(posedge clock);
      #1;
      chk("mask_held", obs_sc.size(), 0);
      sc_ready = 1'b1;
      wait_done();
      finish_check();
      chk("t4_mask", obs_sc.size() > 0 ? obs_sc[0] : 29'h0, {5'b00001, 24'h00FF0F});

      // CHECK_FIFO full during PUSH
      wp = 20'h400;
      rec_run(24'h0F0F0F, 24'hF0F0F0, 8'h77);
      rec_run(24'h123123, 24'h321321, 8'h88);
      put(16'hFF00);
      cfifo_wrfull = 1'b1;
      do_start(20'h400, 20'h01234, 8'd1);
      for (n = 0; n < 200; n++) begin
         @(negedge clock);
         if (capture) break;
      end
      repeat (6) @(posedge clock);
      #1;
      cfifo_wrfull = 1'b0;
      wait_done();
      finish_check();
      chk("push_stall", first_gap, 6);

      // bad meta, then restart clears error
      wp = 20'h500; put(16'h4200);
      do_start(20'h500, 20'h0, 8'd0);
      wait_done();
      finish_check();
      chk("bad_meta_err", error, 1);
      wp = 20'h510; rec_run(24'h00AA55, 24'h55AA00, 8'h3C); put(16'hFF00);
      do_start(20'h510, 20'h00100, 8'd1);
      chk("err_clear", error, 0);
      wait_done();
      finish_check();

      // reset during SETTLE
      wp = 20'h600; rec_run(24'h765432, 24'h234567, 8'h99); put(16'hFF00);
      do_start(20'h600, 20'h0, 8'd50);
      for (n = 0; n < 200; n++) begin
         @(negedge clock);
         if (sc_switching) break;
      end
      repeat (3) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #2;
      chk_zero("mid_reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      exp_last_in = '0;
      @(posedge clock); #1;
      do_start(20'h100, 20'h08000, 8'd3);
      wait_done();
      finish_check();

      // randomized programs
      for (int it = 0; it < 10; it++) begin
         ws_rand   = ($urandom_range(0, 1) == 1);
         full_rand = ($urandom_range(0, 1) == 1);
         vb = (it % 3 == 0) ? 20'hFFFFA : 20'($urandom);
         rb = (it % 4 == 1) ? 20'hFFFFE : 20'($urandom);
         wp = vb;
         nrec = $urandom_range(1, 4);
         for (int r = 0; r < nrec; r++) begin
            if ($urandom_range(0, 2) == 0) rec_mask(24'($urandom));
            else rec_run(24'($urandom), 24'($urandom), 8'($urandom));
         end
         if ($urandom_range(0, 4) == 0) put(16'h4200);
         else put(16'hFF00);
         do_start(vb, rb, 8'($urandom_range(0, 4)));
         wait_done();
         finish_check();
      end
      ws_rand = 0;
      full_rand = 0;
      @(posedge clock); #1;
      cfifo_wrfull = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
